// File: rtl/id_queue_pkg.sv
// Shared encodings, field widths and the decoded control bundle for the
// instruction-decode queue.
package id_queue_pkg;

  localparam int INST_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int CSR_ADDR_WIDTH = 12;

  localparam int OP1_W = 2;
  localparam int OP2_W = 2;
  localparam int ALU_W = 4;
  localparam int BR_W  = 3;
  localparam int WB_W  = 3;
  localparam int MEM_W = 2;
  localparam int SL_W  = 2;

  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG     = 5'd0;
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MDISABLE = 12'h000;

  localparam logic [OP1_W-1:0] OP1_NONE = 2'd0;
  localparam logic [OP1_W-1:0] OP1_RS1  = 2'd1;
  localparam logic [OP1_W-1:0] OP1_PC   = 2'd2;
  localparam logic [OP1_W-1:0] OP1_ZERO = 2'd3;

  localparam logic [OP2_W-1:0] OP2_NONE = 2'd0;
  localparam logic [OP2_W-1:0] OP2_RS2  = 2'd1;
  localparam logic [OP2_W-1:0] OP2_IMM  = 2'd2;

  localparam logic [ALU_W-1:0] ALU_NOP   = 4'd0;
  localparam logic [ALU_W-1:0] ALU_ADD   = 4'd1;
  localparam logic [ALU_W-1:0] ALU_SUB   = 4'd2;
  localparam logic [ALU_W-1:0] ALU_SLL   = 4'd3;
  localparam logic [ALU_W-1:0] ALU_SLT   = 4'd4;
  localparam logic [ALU_W-1:0] ALU_SLTU  = 4'd5;
  localparam logic [ALU_W-1:0] ALU_XOR   = 4'd6;
  localparam logic [ALU_W-1:0] ALU_SRL   = 4'd7;
  localparam logic [ALU_W-1:0] ALU_SRA   = 4'd8;
  localparam logic [ALU_W-1:0] ALU_OR    = 4'd9;
  localparam logic [ALU_W-1:0] ALU_AND   = 4'd10;
  localparam logic [ALU_W-1:0] ALU_CSRRW = 4'd11;
  localparam logic [ALU_W-1:0] ALU_CSRRS = 4'd12;
  localparam logic [ALU_W-1:0] ALU_CSRRC = 4'd13;

  localparam logic [BR_W-1:0] BR_DISABLE = 3'd0;
  localparam logic [BR_W-1:0] BR_BEQ     = 3'd1;
  localparam logic [BR_W-1:0] BR_BNE     = 3'd2;
  localparam logic [BR_W-1:0] BR_BLT     = 3'd3;
  localparam logic [BR_W-1:0] BR_BGE     = 3'd4;
  localparam logic [BR_W-1:0] BR_BLTU    = 3'd5;
  localparam logic [BR_W-1:0] BR_BGEU    = 3'd6;
  localparam logic [BR_W-1:0] BR_JUMP    = 3'd7;

  localparam logic [WB_W-1:0] WB_NONE = 3'd0;
  localparam logic [WB_W-1:0] WB_ALU  = 3'd1;
  localparam logic [WB_W-1:0] WB_MEM  = 3'd2;
  localparam logic [WB_W-1:0] WB_PC4  = 3'd3;
  localparam logic [WB_W-1:0] WB_CSR  = 3'd4;

  localparam logic [MEM_W-1:0] MEM_DISABLE = 2'd0;
  localparam logic [MEM_W-1:0] MEM_READ    = 2'd1;
  localparam logic [MEM_W-1:0] MEM_WRITE   = 2'd2;

  localparam logic [SL_W-1:0] SL_NONE = 2'd0;
  localparam logic [SL_W-1:0] SL_BYTE = 2'd1;
  localparam logic [SL_W-1:0] SL_HALF = 2'd2;
  localparam logic [SL_W-1:0] SL_WORD = 2'd3;

  localparam logic LOAD_SIGNED   = 1'b1;
  localparam logic LOAD_UNSIGNED = 1'b0;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [INST_WIDTH-1:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [INST_WIDTH-1:0] INST_EBREAK = 32'h0010_0073;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [CSR_ADDR_WIDTH-1:0] csr;
    logic [OP1_W-1:0]          op1;
    logic [OP2_W-1:0]          op2;
    logic [ALU_W-1:0]          alu;
    logic [BR_W-1:0]           br;
    logic [WB_W-1:0]           wb;
    logic [MEM_W-1:0]          mem;
    logic [SL_W-1:0]           sl;
    logic                      load_sign;
    logic                      illegal;
    logic                      ecall;
    logic                      ebreak;
  } ctrl_t;

  // Bundle used for reset contents and for squashing illegal/system entries.
  function automatic ctrl_t ctrl_nop();
    ctrl_t c;
    c.rs1       = ZERO_REG;
    c.rs2       = ZERO_REG;
    c.rd        = ZERO_REG;
    c.csr       = CSR_MDISABLE;
    c.op1       = OP1_NONE;
    c.op2       = OP2_NONE;
    c.alu       = ALU_NOP;
    c.br        = BR_DISABLE;
    c.wb        = WB_NONE;
    c.mem       = MEM_DISABLE;
    c.sl        = SL_NONE;
    c.load_sign = LOAD_SIGNED;
    c.illegal   = 1'b0;
    c.ecall     = 1'b0;
    c.ebreak    = 1'b0;
    return c;
  endfunction

  function automatic logic opcode_known(input logic [6:0] opc);
    logic known;
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
      OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_FENCE, OPC_SYSTEM: known = 1'b1;
      default:                                              known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/id_queue_if.sv
// Fetch-side and execute-side handshake plus decoded head fields of id_queue.
interface id_queue_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 2
);
  import id_queue_pkg::*;

  logic                      flush_i;
  logic                      in_valid_i;
  logic                      in_ready_o;
  logic [INST_WIDTH-1:0]     inst_i;
  logic [XLEN-1:0]           inst_addr_i;
  logic                      out_valid_o;
  logic                      out_ready_i;
  logic [INST_WIDTH-1:0]     inst_o;
  logic [XLEN-1:0]           inst_addr_o;
  logic [REG_ADDR_WIDTH-1:0] rs1_raddr_o;
  logic [REG_ADDR_WIDTH-1:0] rs2_raddr_o;
  logic [REG_ADDR_WIDTH-1:0] rd_waddr_o;
  logic [CSR_ADDR_WIDTH-1:0] csr_addr_o;
  logic [XLEN-1:0]           imm_o;
  logic [OP1_W-1:0]          op1_sel_o;
  logic [OP2_W-1:0]          op2_sel_o;
  logic [ALU_W-1:0]          alu_sel_o;
  logic [BR_W-1:0]           br_sel_o;
  logic [WB_W-1:0]           wb_sel_o;
  logic [MEM_W-1:0]          mem_rw_o;
  logic [SL_W-1:0]           byte_sel_o;
  logic                      load_sign_o;
  logic                      illegal_o;
  logic                      ecall_o;
  logic                      ebreak_o;
  logic [CNT_W-1:0]          count_o;

  modport slave (
    input  flush_i, in_valid_i, inst_i, inst_addr_i, out_ready_i,
    output in_ready_o, out_valid_o, inst_o, inst_addr_o, rs1_raddr_o,
           rs2_raddr_o, rd_waddr_o, csr_addr_o, imm_o, op1_sel_o, op2_sel_o,
           alu_sel_o, br_sel_o, wb_sel_o, mem_rw_o, byte_sel_o, load_sign_o,
           illegal_o, ecall_o, ebreak_o, count_o
  );

  modport master (
    output flush_i, in_valid_i, inst_i, inst_addr_i, out_ready_i,
    input  in_ready_o, out_valid_o, inst_o, inst_addr_o, rs1_raddr_o,
           rs2_raddr_o, rd_waddr_o, csr_addr_o, imm_o, op1_sel_o, op2_sel_o,
           alu_sel_o, br_sel_o, wb_sel_o, mem_rw_o, byte_sel_o, load_sign_o,
           illegal_o, ecall_o, ebreak_o, count_o
  );

endinterface

// File: rtl/id_decode_core.sv
// Combinational RV32I/Zicsr decoder: one instruction word to a control bundle
// plus immediate, with illegal/ECALL/EBREAK detection.
module id_decode_core
  import id_queue_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [INST_WIDTH-1:0] inst_i,
  output ctrl_t                 ctrl_o,
  output logic [XLEN-1:0]       imm_o
);

  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [6:0]  funct7_s;
  logic [31:0] imm_i_s;
  logic [31:0] imm_s_s;
  logic [31:0] imm_b_s;
  logic [31:0] imm_u_s;
  logic [31:0] imm_j_s;
  logic [31:0] imm_raw_s;
  logic [31:0] imm_fin_s;
  ctrl_t       dec_s;
  logic        illegal_s;
  logic        ecall_s;
  logic        ebreak_s;

  assign opcode_s = inst_i[6:0];
  assign funct3_s = inst_i[14:12];
  assign funct7_s = inst_i[31:25];
  assign imm_i_s  = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_s_s  = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b_s  = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_u_s  = {inst_i[31:12], 12'd0};
  assign imm_j_s  = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

  // Field decode per opcode; illegal encodings only raise illegal_s here.
  always_comb begin
    dec_s     = ctrl_nop();
    imm_raw_s = 32'd0;
    illegal_s = ~opcode_known(opcode_s) | (inst_i[1:0] != 2'b11);
    ecall_s   = 1'b0;
    ebreak_s  = 1'b0;
    case (opcode_s)
      OPC_LUI, OPC_AUIPC: begin
        dec_s.rd  = inst_i[11:7];
        dec_s.op1 = (opcode_s == OPC_LUI) ? OP1_ZERO : OP1_PC;
        dec_s.op2 = OP2_IMM;
        dec_s.alu = ALU_ADD;
        dec_s.wb  = WB_ALU;
        imm_raw_s = imm_u_s;
      end
      OPC_JAL, OPC_JALR: begin
        dec_s.rd  = inst_i[11:7];
        dec_s.rs1 = (opcode_s == OPC_JALR) ? inst_i[19:15] : ZERO_REG;
        dec_s.op1 = (opcode_s == OPC_JALR) ? OP1_RS1 : OP1_PC;
        dec_s.op2 = OP2_IMM;
        dec_s.alu = ALU_ADD;
        dec_s.br  = BR_JUMP;
        dec_s.wb  = WB_PC4;
        imm_raw_s = (opcode_s == OPC_JALR) ? imm_i_s : imm_j_s;
      end
      OPC_BRANCH: begin
        dec_s.rs1 = inst_i[19:15];
        dec_s.rs2 = inst_i[24:20];
        dec_s.op1 = OP1_PC;
        dec_s.op2 = OP2_IMM;
        dec_s.alu = ALU_ADD;
        imm_raw_s = imm_b_s;
        case (funct3_s)
          3'd0:    dec_s.br = BR_BEQ;
          3'd1:    dec_s.br = BR_BNE;
          3'd4:    dec_s.br = BR_BLT;
          3'd5:    dec_s.br = BR_BGE;
          3'd6:    dec_s.br = BR_BLTU;
          3'd7:    dec_s.br = BR_BGEU;
          default: illegal_s = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec_s.rs1       = inst_i[19:15];
        dec_s.rd        = inst_i[11:7];
        dec_s.op1       = OP1_RS1;
        dec_s.op2       = OP2_IMM;
        dec_s.alu       = ALU_ADD;
        dec_s.mem       = MEM_READ;
        dec_s.wb        = WB_MEM;
        dec_s.load_sign = funct3_s[2] ? LOAD_UNSIGNED : LOAD_SIGNED;
        imm_raw_s       = imm_i_s;
        case (funct3_s)
          3'd0, 3'd4: dec_s.sl = SL_BYTE;
          3'd1, 3'd5: dec_s.sl = SL_HALF;
          3'd2:       dec_s.sl = SL_WORD;
          default:    illegal_s = 1'b1;
        endcase
      end
      OPC_STORE: begin
        dec_s.rs1 = inst_i[19:15];
        dec_s.rs2 = inst_i[24:20];
        dec_s.op1 = OP1_RS1;
        dec_s.op2 = OP2_IMM;
        dec_s.alu = ALU_ADD;
        dec_s.mem = MEM_WRITE;
        imm_raw_s = imm_s_s;
        case (funct3_s)
          3'd0:    dec_s.sl = SL_BYTE;
          3'd1:    dec_s.sl = SL_HALF;
          3'd2:    dec_s.sl = SL_WORD;
          default: illegal_s = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        dec_s.rs1 = inst_i[19:15];
        dec_s.rd  = inst_i[11:7];
        dec_s.op1 = OP1_RS1;
        dec_s.op2 = OP2_IMM;
        dec_s.wb  = WB_ALU;
        imm_raw_s = imm_i_s;
        case (funct3_s)
          3'd0: dec_s.alu = ALU_ADD;
          3'd2: dec_s.alu = ALU_SLT;
          3'd3: dec_s.alu = ALU_SLTU;
          3'd4: dec_s.alu = ALU_XOR;
          3'd6: dec_s.alu = ALU_OR;
          3'd7: dec_s.alu = ALU_AND;
          3'd1: begin
            imm_raw_s = {27'd0, inst_i[24:20]};
            dec_s.alu = ALU_SLL;
            illegal_s = illegal_s | (funct7_s != 7'h00);
          end
          default: begin
            // Shift amount only; the funct7 bit must not leak into the operand.
            imm_raw_s = {27'd0, inst_i[24:20]};
            dec_s.alu = (funct7_s == 7'h20) ? ALU_SRA : ALU_SRL;
            illegal_s = illegal_s | ((funct7_s != 7'h00) & (funct7_s != 7'h20));
          end
        endcase
      end
      OPC_OP: begin
        dec_s.rs1 = inst_i[19:15];
        dec_s.rs2 = inst_i[24:20];
        dec_s.rd  = inst_i[11:7];
        dec_s.op1 = OP1_RS1;
        dec_s.op2 = OP2_RS2;
        dec_s.wb  = WB_ALU;
        case ({funct7_s, funct3_s})
          {7'h00, 3'd0}: dec_s.alu = ALU_ADD;
          {7'h00, 3'd1}: dec_s.alu = ALU_SLL;
          {7'h00, 3'd2}: dec_s.alu = ALU_SLT;
          {7'h00, 3'd3}: dec_s.alu = ALU_SLTU;
          {7'h00, 3'd4}: dec_s.alu = ALU_XOR;
          {7'h00, 3'd5}: dec_s.alu = ALU_SRL;
          {7'h00, 3'd6}: dec_s.alu = ALU_OR;
          {7'h00, 3'd7}: dec_s.alu = ALU_AND;
          {7'h20, 3'd0}: dec_s.alu = ALU_SUB;
          {7'h20, 3'd5}: dec_s.alu = ALU_SRA;
          default:       illegal_s = 1'b1;
        endcase
      end
      OPC_FENCE: begin
        illegal_s = illegal_s | (funct3_s[2:1] != 2'b00);
      end
      OPC_SYSTEM: begin
        case (funct3_s)
          3'd0: begin
            ecall_s   = (inst_i == INST_ECALL);
            ebreak_s  = (inst_i == INST_EBREAK);
            illegal_s = illegal_s | ~(ecall_s | ebreak_s);
          end
          3'd4: illegal_s = 1'b1;
          default: begin
            dec_s.rd  = inst_i[11:7];
            dec_s.csr = inst_i[31:20];
            dec_s.wb  = WB_CSR;
            case (funct3_s[1:0])
              2'd1:    dec_s.alu = ALU_CSRRW;
              2'd2:    dec_s.alu = ALU_CSRRS;
              default: dec_s.alu = ALU_CSRRC;
            endcase
            if (funct3_s[2]) begin
              dec_s.op2 = OP2_IMM;
              imm_raw_s = {27'd0, inst_i[19:15]};
            end else begin
              dec_s.rs1 = inst_i[19:15];
              dec_s.op1 = OP1_RS1;
            end
          end
        endcase
      end
      default: dec_s = ctrl_nop();
    endcase
  end

  // Squash everything but the exception flag for illegal and trap entries.
  always_comb begin
    ctrl_o    = ctrl_nop();
    imm_fin_s = 32'd0;
    if (illegal_s) begin
      ctrl_o.illegal = 1'b1;
    end else if (ecall_s | ebreak_s) begin
      ctrl_o.ecall  = ecall_s;
      ctrl_o.ebreak = ebreak_s;
    end else begin
      ctrl_o    = dec_s;
      imm_fin_s = imm_raw_s;
    end
  end

  assign imm_o = XLEN'($signed(imm_fin_s));

endmodule

// File: rtl/id_queue.sv
// Registered decode queue: decodes the fetch word on push and holds DEPTH
// decoded bundles; all head outputs come from the entry registers.
module id_queue
  import id_queue_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic       clk,
  input  logic       rst,
  id_queue_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);

  ctrl_t                 dec_ctrl_s;
  logic [XLEN-1:0]       dec_imm_s;
  logic                  in_ready_s;
  logic                  out_valid_s;
  logic                  push_s;
  logic                  pop_s;

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  ctrl_t                 ctrl_mem_q [DEPTH];
  ctrl_t                 ctrl_mem_d [DEPTH];
  logic [XLEN-1:0]       imm_mem_q  [DEPTH];
  logic [XLEN-1:0]       imm_mem_d  [DEPTH];
  logic [INST_WIDTH-1:0] inst_mem_q [DEPTH];
  logic [INST_WIDTH-1:0] inst_mem_d [DEPTH];
  logic [XLEN-1:0]       addr_mem_q [DEPTH];
  logic [XLEN-1:0]       addr_mem_d [DEPTH];

  id_decode_core #(.XLEN(XLEN)) u_decode (
    .inst_i (bus.inst_i),
    .ctrl_o (dec_ctrl_s),
    .imm_o  (dec_imm_s)
  );

  // Ready looks only at occupancy and flush, so a full queue cannot accept
  // in the same cycle it is drained.
  assign in_ready_s  = (count_q != CNT_W'(DEPTH)) & ~bus.flush_i;
  assign out_valid_s = (count_q != CNT_W'(0));
  assign push_s      = bus.in_valid_i & in_ready_s & ~bus.flush_i;
  assign pop_s       = out_valid_s & bus.out_ready_i & ~bus.flush_i;

  // Next-state for pointers, occupancy and entry storage.
  always_comb begin
    ctrl_mem_d = ctrl_mem_q;
    imm_mem_d  = imm_mem_q;
    inst_mem_d = inst_mem_q;
    addr_mem_d = addr_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push_s) begin
      ctrl_mem_d[wr_ptr_q] = dec_ctrl_s;
      imm_mem_d[wr_ptr_q]  = dec_imm_s;
      inst_mem_d[wr_ptr_q] = bus.inst_i;
      addr_mem_d[wr_ptr_q] = bus.inst_addr_i;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (bus.flush_i) begin
      wr_ptr_d = PTR_W'(0);
      rd_ptr_d = PTR_W'(0);
      count_d  = CNT_W'(0);
    end else begin
      count_d = count_d;
    end
  end

  // State registers; entries reset to the NOP bundle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= PTR_W'(0);
      rd_ptr_q <= PTR_W'(0);
      count_q  <= CNT_W'(0);
      for (int i = 0; i < DEPTH; i++) begin
        ctrl_mem_q[i] <= ctrl_nop();
        imm_mem_q[i]  <= XLEN'(0);
        inst_mem_q[i] <= 32'd0;
        addr_mem_q[i] <= XLEN'(0);
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ctrl_mem_q <= ctrl_mem_d;
      imm_mem_q  <= imm_mem_d;
      inst_mem_q <= inst_mem_d;
      addr_mem_q <= addr_mem_d;
    end
  end

  assign bus.in_ready_o  = in_ready_s;
  assign bus.out_valid_o = out_valid_s;
  assign bus.count_o     = count_q;
  assign bus.inst_o      = inst_mem_q[rd_ptr_q];
  assign bus.inst_addr_o = addr_mem_q[rd_ptr_q];
  assign bus.imm_o       = imm_mem_q[rd_ptr_q];
  assign bus.rs1_raddr_o = ctrl_mem_q[rd_ptr_q].rs1;
  assign bus.rs2_raddr_o = ctrl_mem_q[rd_ptr_q].rs2;
  assign bus.rd_waddr_o  = ctrl_mem_q[rd_ptr_q].rd;
  assign bus.csr_addr_o  = ctrl_mem_q[rd_ptr_q].csr;
  assign bus.op1_sel_o   = ctrl_mem_q[rd_ptr_q].op1;
  assign bus.op2_sel_o   = ctrl_mem_q[rd_ptr_q].op2;
  assign bus.alu_sel_o   = ctrl_mem_q[rd_ptr_q].alu;
  assign bus.br_sel_o    = ctrl_mem_q[rd_ptr_q].br;
  assign bus.wb_sel_o    = ctrl_mem_q[rd_ptr_q].wb;
  assign bus.mem_rw_o    = ctrl_mem_q[rd_ptr_q].mem;
  assign bus.byte_sel_o  = ctrl_mem_q[rd_ptr_q].sl;
  assign bus.load_sign_o = ctrl_mem_q[rd_ptr_q].load_sign;
  assign bus.illegal_o   = ctrl_mem_q[rd_ptr_q].illegal;
  assign bus.ecall_o     = ctrl_mem_q[rd_ptr_q].ecall;
  assign bus.ebreak_o    = ctrl_mem_q[rd_ptr_q].ebreak;

endmodule
